inst_encoder: RTL and testbench
===============================

Name: inst_encoder

Overview:
- Encode direction of the immediate path: takes decoded instruction fields plus a full 32-bit immediate and packs them into a 32-bit RV32I instruction word.
- Scatters immediate bits exactly inverse to the decoder's sign-extending extraction.
- Checks each immediate for encodability; stamps every good word with a sequential instruction-memory word address.
- Feeds the imem loader / self-test program builder through a 2-entry valid/ready output buffer.

Parameters:
ADDR_W, 10, width of the word-address counter; wraps modulo 2^ADDR_W.
BASE_ADDR, 0, address loaded on reset and on clear.

Ports:
clk  input  1  single clock; all logic on its rising edge
rst_n  input  1  asynchronous, active-low reset
clear  input  1  synchronous flush: empties the buffer, resets the address and error state
in_valid  input  1  request valid
in_ready  output  1  request accepted when in_valid && in_ready
imm_type  input  3  000 I, 001 J, 010 U, 011 B, 100 S, 101 R (no imm); 110/111 illegal
opcode  input  7  inst[6:0]
rd  input  5  destination register
funct3  input  3  funct3
rs1  input  5  source register 1
rs2  input  5  source register 2
funct7  input  7  R-type only
imm  input  32  full signed immediate value (not pre-shifted, except U: U expects the final value, with imm[11:0]==0)
out_valid  output  1  word available
out_ready  input  1  consumer accepts word
out_inst  output  32  encoded instruction
out_addr  output  ADDR_W  word address of out_inst
err_sticky  output  1  set by any dropped request; cleared by reset/clear
err_cnt  output  8  count of dropped requests, saturates at 255

Behaviour:
- Reset (rst_n low, async): buffer empty, out_valid=0, out_inst=0, out_addr=BASE_ADDR, addr counter=BASE_ADDR, err_sticky=0, err_cnt=0, in_ready=0 while reset asserted.
- Packing (a bit list like [11:0] means those bits of imm):
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U: {imm[31:12], rd, opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
  - R: {funct7, rs2, rs1, funct3, rd, opcode}; imm ignored.
- Legality:
  - I/S: imm[31:11] all equal.
  - B: imm[0]==0 and imm[31:12] all equal.
  - J: imm[0]==0 and imm[31:20] all equal.
  - U: imm[11:0]==0.
  - R: always legal.
  - 110/111: illegal.
- Accepting an illegal request consumes it:
  - nothing is pushed and the addr counter does not change;
  - err_sticky<=1, err_cnt<=sat(err_cnt+1).
- Accepting a legal request pushes {inst, addr counter} into the buffer; the addr counter increments, wrapping 2^ADDR_W-1 -> 0.
- Latency: a word accepted into an empty buffer appears on out_valid the next cycle.
- Buffer: 2-entry FIFO, in-order, registered outputs.
  - in_ready = (count<2) && !clear.
  - Push and pop in the same cycle at count 1: count stays 1 and order is preserved.
  - At count 2, in_ready=0; no push is attempted.
- out_inst/out_addr hold stable while out_valid && !out_ready (no change under backpressure).
- clear has priority over all other activity: input not accepted that cycle, buffer emptied (out_valid=0 next cycle), addr counter=BASE_ADDR, err state zeroed.
- Round-trip invariant: for legal inputs, the decoder's immediate output on (out_inst, imm_type) equals imm.

Decomposition:
- Package inst_enc_pkg:
  - imm_type_e enum (codes above, shared with the immediate decoder);
  - RV32I opcode localparams (OP_IMM 7'h13, STORE 7'h23, BRANCH 7'h63, JAL 7'h6F, LUI 7'h37, OP 7'h33).
- Combinational sub-module inst_pack: fields -> {inst[31:0], legal}.
- Top holds the FIFO, address counter and error counters.

Test Plan:
- I: type I, opcode 0x13, rd 1, rs1 0, funct3 0, imm 0xFFFFFFFF -> out_inst 0xFFF00093, out_addr 0, one cycle after accept.
- S then J back-to-back:
  - S: rs2 2, rs1 1, funct3 2, imm 4, opcode 0x23 -> 0x0020A223 @0.
  - J: rd 1, imm 8, opcode 0x6F -> 0x008000EF @1.
- Illegal: B with imm 3, then U with imm 0x1001, then type 111 -> no outputs, err_cnt 3, err_sticky 1, addr counter still 0; the next legal word gets addr 0.
- Backpressure: out_ready=0, offer 3 legal requests -> in_ready low after 2 accepts; release -> all 3 words emerge in order, addrs 0,1,2, words stable while stalled.
- Wrap (ADDR_W=2): 5 legal words -> addrs 0,1,2,3,0.
- clear mid-stream with 2 words buffered and in_valid high -> input not accepted, out_valid 0 next cycle, next word at BASE_ADDR, err_cnt 0; async rst_n pulse mid-stall -> all outputs to reset values immediately.

Source files
------------

// File: rtl/inst_encoder_pkg.sv
// Shared types and constants for the RV32I instruction encoder and its
// companion immediate decoder.
package inst_enc_pkg;

  // Immediate format selector; the same codes are used by the decoder.
  typedef enum logic [2:0] {
    IMM_I  = 3'b000,
    IMM_J  = 3'b001,
    IMM_U  = 3'b010,
    IMM_B  = 3'b011,
    IMM_S  = 3'b100,
    IMM_R  = 3'b101,
    IMM_X6 = 3'b110,
    IMM_X7 = 3'b111
  } imm_type_e;

  // RV32I major opcodes used by the program builder.
  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] STORE  = 7'h23;
  localparam logic [6:0] BRANCH = 7'h63;
  localparam logic [6:0] JAL    = 7'h6F;
  localparam logic [6:0] LUI    = 7'h37;
  localparam logic [6:0] OP     = 7'h33;

  // One encode request as seen by the packer.
  typedef struct packed {
    imm_type_e   imm_type;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } inst_req_t;

  // True when v[31:msb] are all equal, i.e. v survives a sign-extending
  // extraction of its low msb+1 bits.
  function automatic logic upper_same(input logic [31:0] v, input int unsigned msb);
    logic [31:0] m;
    m = 32'hFFFF_FFFF << msb;
    return ((v & m) == m) || ((v & m) == 32'h0);
  endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Request/response bundle between the program builder and the encoder.
interface inst_enc_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        imm_type;
  logic [6:0]        opcode;
  logic [4:0]        rd;
  logic [2:0]        funct3;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [6:0]        funct7;
  logic [31:0]       imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_addr;

  // Producer of requests / consumer of encoded words.
  modport master (
    output in_valid, imm_type, opcode, rd, funct3, rs1, rs2, funct7, imm, out_ready,
    input  in_ready, out_valid, out_inst, out_addr
  );

  // The encoder itself.
  modport slave (
    input  in_valid, imm_type, opcode, rd, funct3, rs1, rs2, funct7, imm, out_ready,
    output in_ready, out_valid, out_inst, out_addr
  );
endinterface

// File: rtl/inst_encoder_pack.sv
// Combinational packer: scatters the immediate into its RV32I bit slots
// (exact inverse of the decoder's extraction) and flags unencodable values.
module inst_pack
  import inst_enc_pkg::*;
(
  input  inst_req_t   req,
  output logic [31:0] inst,
  output logic        legal
);

  // Per-format bit placement and encodability check.
  always_comb begin
    inst  = 32'h0;
    legal = 1'b0;
    case (req.imm_type)
      IMM_I: begin
        inst  = {req.imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
        legal = upper_same(req.imm, 11);
      end
      IMM_S: begin
        inst  = {req.imm[11:5], req.rs2, req.rs1, req.funct3, req.imm[4:0], req.opcode};
        legal = upper_same(req.imm, 11);
      end
      IMM_B: begin
        inst  = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                 req.imm[4:1], req.imm[11], req.opcode};
        legal = !req.imm[0] && upper_same(req.imm, 12);
      end
      IMM_U: begin
        inst  = {req.imm[31:12], req.rd, req.opcode};
        legal = (req.imm[11:0] == 12'h0);
      end
      IMM_J: begin
        inst  = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12], req.rd, req.opcode};
        legal = !req.imm[0] && upper_same(req.imm, 20);
      end
      IMM_R: begin
        inst  = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, req.opcode};
        legal = 1'b1;
      end
      default: begin
        inst  = 32'h0;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs request fields into a 32-bit word,
// stamps legal words with a sequential imem word address and hands them
// out through a 2-entry in-order buffer. Illegal requests are consumed and
// counted instead of being emitted.
module inst_encoder
  import inst_enc_pkg::*;
#(
  parameter int                ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
)(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  inst_enc_if.slave    bus,
  output logic         err_sticky,
  output logic [7:0]   err_cnt
);

  inst_req_t         req_p0;
  logic [31:0]       inst_p0;
  logic              legal_p0;

  logic [1:0]        count;
  logic [31:0]       head_inst_p1;
  logic [31:0]       tail_inst_p1;
  logic [ADDR_W-1:0] head_addr_p1;
  logic [ADDR_W-1:0] tail_addr_p1;
  logic [ADDR_W-1:0] addr_cnt;

  logic              accept;
  logic              push;
  logic              drop;
  logic              pop;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign req_p0 = '{
    imm_type: imm_type_e'(bus.imm_type),
    opcode:   bus.opcode,
    rd:       bus.rd,
    funct3:   bus.funct3,
    rs1:      bus.rs1,
    rs2:      bus.rs2,
    funct7:   bus.funct7,
    imm:      bus.imm
  };

  inst_pack u_pack (
    .req   (req_p0),
    .inst  (inst_p0),
    .legal (legal_p0)
  );

  // Ready is held low through reset and during a flush.
  assign bus.in_ready  = rst_n && !clear && (count != 2'd2);
  assign accept        = bus.in_valid && bus.in_ready;
  assign push          = accept && legal_p0;
  assign drop          = accept && !legal_p0;
  assign pop           = (count != 2'd0) && bus.out_ready;

  assign bus.out_valid = (count != 2'd0);
  assign bus.out_inst  = head_inst_p1;
  assign bus.out_addr  = head_addr_p1;

  // ---- stage p0 -> p1: head slot (drives the outputs) and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count        <= 2'd0;
      head_inst_p1 <= 32'h0;
      head_addr_p1 <= BASE_ADDR;
    end else if (clear) begin
      count <= 2'd0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            head_inst_p1 <= inst_p0;
            head_addr_p1 <= addr_cnt;
            count        <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_inst_p1 <= inst_p0;
            head_addr_p1 <= addr_cnt;
          end else if (push) begin
            count <= 2'd2;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            head_inst_p1 <= tail_inst_p1;
            head_addr_p1 <= tail_addr_p1;
            count        <= 2'd1;
          end
        end
        default: count <= 2'd0;
      endcase
    end
  end

  // Tail slot: only written when a word queues behind a stalled head.
  always_ff @(posedge clk) begin
    if (push && (count == 2'd1) && !pop) begin
      tail_inst_p1 <= inst_p0;
      tail_addr_p1 <= addr_cnt;
    end
  end

  // Word-address counter and dropped-request bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_cnt   <= BASE_ADDR;
      err_sticky <= 1'b0;
      err_cnt    <= 8'h0;
    end else if (clear) begin
      addr_cnt   <= BASE_ADDR;
      err_sticky <= 1'b0;
      err_cnt    <= 8'h0;
    end else begin
      if (push) begin
        addr_cnt <= addr_cnt + 1'b1;
      end
      if (drop) begin
        err_sticky <= 1'b1;
        err_cnt    <= sat_inc(err_cnt);
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: directed requests, a spec-level model with a
// per-cycle scoreboard compare, and literal expectations.
module tb_inst_encoder;
  import inst_enc_pkg::*;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          err_sticky;
  logic [7:0]    err_cnt;

  inst_enc_if #(.ADDR_W(AW)) bus ();

  inst_encoder #(.ADDR_W(AW), .BASE_ADDR(2'd0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .bus        (bus.slave),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    $display("FAIL %s: request not accepted within bound", nm);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0]   inst;
    logic [AW-1:0] addr;
    logic [2:0]    t;
    logic [31:0]   imm;
  } ent_t;

  ent_t          q[$];
  logic [AW-1:0] m_addr = '0;
  int            m_err = 0;
  bit            m_sticky = 0;
  logic [AW-1:0] obs_addr[$];
  logic [31:0]   obs_inst[$];

  function automatic logic [31:0] model_enc(input logic [2:0] t, input logic [6:0] op,
      input logic [4:0] rd, input logic [2:0] f3, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [6:0] f7, input logic [31:0] imm);
    case (t)
      3'd0:    return {imm[11:0], rs1, f3, rd, op};
      3'd4:    return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      3'd3:    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      3'd2:    return {imm[31:12], rd, op};
      3'd1:    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      3'd5:    return {f7, rs2, rs1, f3, rd, op};
      default: return 32'h0;
    endcase
  endfunction

  // Encodability as signed ranges and alignment.
  function automatic bit model_legal(input logic [2:0] t, input logic [31:0] imm);
    longint s;
    s = longint'($signed(imm));
    case (t)
      3'd0, 3'd4: return (s >= -2048) && (s <= 2047);
      3'd3:       return (imm[0] == 1'b0) && (s >= -4096) && (s <= 4095);
      3'd1:       return (imm[0] == 1'b0) && (s >= -1048576) && (s <= 1048575);
      3'd2:       return imm[11:0] == 12'h0;
      3'd5:       return 1'b1;
      default:    return 1'b0;
    endcase
  endfunction

  // Decoder-side sign-extending extraction, used for the round-trip check.
  function automatic logic [31:0] model_dec(input logic [31:0] w, input logic [2:0] t);
    case (t)
      3'd0:    return {{20{w[31]}}, w[31:20]};
      3'd4:    return {{20{w[31]}}, w[31:25], w[11:7]};
      3'd3:    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'd2:    return {w[31:12], 12'h0};
      3'd1:    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  // Compare DUT against model every cycle, then advance the model.
  always @(negedge clk) begin : monitor
    bit exp_rdy;
    if (!rst_n) begin
      q.delete();
      m_addr   = '0;
      m_err    = 0;
      m_sticky = 0;
      check("rst out_valid", bus.out_valid, 0);
      check("rst out_inst", bus.out_inst, 0);
      check("rst out_addr", bus.out_addr, 0);
      check("rst in_ready", bus.in_ready, 0);
      check("rst err_cnt", err_cnt, 0);
      check("rst err_sticky", err_sticky, 0);
    end else begin
      exp_rdy = (q.size() < 2) && !clear;
      check("in_ready", bus.in_ready, exp_rdy);
      check("out_valid", bus.out_valid, q.size() != 0);
      if (q.size() != 0) begin
        check("out_inst", bus.out_inst, q[0].inst);
        check("out_addr", bus.out_addr, q[0].addr);
        if (q[0].t != 3'd5) check("round-trip imm", model_dec(bus.out_inst, q[0].t), q[0].imm);
      end
      check("err_cnt", err_cnt, m_err);
      check("err_sticky", err_sticky, m_sticky);
      if (bus.out_valid && bus.out_ready) begin
        obs_addr.push_back(bus.out_addr);
        obs_inst.push_back(bus.out_inst);
      end
      if (clear) begin
        q.delete();
        m_addr   = '0;
        m_err    = 0;
        m_sticky = 0;
      end else begin
        if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
        if (bus.in_valid && exp_rdy) begin
          if (model_legal(bus.imm_type, bus.imm)) begin
            q.push_back('{inst: model_enc(bus.imm_type, bus.opcode, bus.rd, bus.funct3,
                                          bus.rs1, bus.rs2, bus.funct7, bus.imm),
                          addr: m_addr, t: bus.imm_type, imm: bus.imm});
            m_addr = m_addr + 1'b1;
          end else begin
            m_err    = (m_err >= 255) ? 255 : m_err + 1;
            m_sticky = 1;
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [2:0] t, input logic [6:0] op, input logic [4:0] rd,
      input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [6:0] f7, input logic [31:0] imm);
    bus.imm_type = t;
    bus.opcode   = op;
    bus.rd       = rd;
    bus.funct3   = f3;
    bus.rs1      = rs1;
    bus.rs2      = rs2;
    bus.funct7   = f7;
    bus.imm      = imm;
    bus.in_valid = 1'b1;
  endtask

  task automatic wait_acc(input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
    end
    if (!ok) timeout(nm);
    sync();
    bus.in_valid = 1'b0;
  endtask

  task automatic send(input logic [2:0] t, input logic [6:0] op, input logic [4:0] rd,
      input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [6:0] f7, input logic [31:0] imm, input string nm);
    set_req(t, op, rd, f3, rs1, rs2, f7, imm);
    wait_acc(nm);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    sync();
    clear = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) sync();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    set_req(3'd0, 7'h0, 5'd0, 3'd0, 5'd0, 5'd0, 7'h0, 32'h0);
    bus.in_valid = 1'b0;

    // Pin the model with hand-encoded words and legality boundaries.
    check("pin I", model_enc(3'd0, OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 7'h0, 32'hFFFFFFFF), 32'hFFF00093);
    check("pin S", model_enc(3'd4, STORE, 5'd0, 3'd2, 5'd1, 5'd2, 7'h0, 32'd4), 32'h0020A223);
    check("pin J", model_enc(3'd1, JAL, 5'd1, 3'd0, 5'd0, 5'd0, 7'h0, 32'd8), 32'h008000EF);
    check("pin B", model_enc(3'd3, BRANCH, 5'd0, 3'd0, 5'd0, 5'd0, 7'h0, 32'hFFFFFFFC), 32'hFE000EE3);
    check("pin U", model_enc(3'd2, LUI, 5'd5, 3'd0, 5'd0, 5'd0, 7'h0, 32'h12345000), 32'h123452B7);
    check("pin R", model_enc(3'd5, OP, 5'd3, 3'd0, 5'd1, 5'd2, 7'h0, 32'h0), 32'h002081B3);
    check("pin legal I 2048", model_legal(3'd0, 32'h00000800), 0);
    check("pin legal B odd", model_legal(3'd3, 32'd3), 0);
    check("pin legal J max", model_legal(3'd1, 32'h000FFFFE), 1);

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    sync();

    // I-type, visible one cycle after accept.
    send(3'd0, OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 7'h0, 32'hFFFFFFFF, "I");
    @(negedge clk);
    check("I out_valid", bus.out_valid, 1);
    check("I out_inst", bus.out_inst, 32'hFFF00093);
    check("I out_addr", bus.out_addr, 0);
    sync();
    idle(2);
    do_clear();

    // S then J back to back.
    obs_addr.delete(); obs_inst.delete();
    send(3'd4, STORE, 5'd0, 3'd2, 5'd1, 5'd2, 7'h0, 32'd4, "S");
    send(3'd1, JAL, 5'd1, 3'd0, 5'd0, 5'd0, 7'h0, 32'd8, "J");
    idle(3);
    check("SJ count", obs_inst.size(), 2);
    if (obs_inst.size() == 2) begin
      check("S inst", obs_inst[0], 32'h0020A223);
      check("S addr", obs_addr[0], 0);
      check("J inst", obs_inst[1], 32'h008000EF);
      check("J addr", obs_addr[1], 1);
    end
    do_clear();

    // Illegal requests are consumed without output or address change.
    obs_addr.delete(); obs_inst.delete();
    send(3'd3, BRANCH, 5'd0, 3'd0, 5'd0, 5'd0, 7'h0, 32'd3, "ill B");
    send(3'd2, LUI, 5'd1, 3'd0, 5'd0, 5'd0, 7'h0, 32'h00001001, "ill U");
    send(3'd7, OP, 5'd1, 3'd0, 5'd0, 5'd0, 7'h0, 32'h0, "ill 7");
    @(negedge clk);
    check("ill err_cnt", err_cnt, 3);
    check("ill sticky", err_sticky, 1);
    check("ill no output", obs_inst.size(), 0);
    sync();
    send(3'd0, OP_IMM, 5'd2, 3'd0, 5'd0, 5'd0, 7'h0, 32'd5, "after ill");
    idle(2);
    check("after ill count", obs_inst.size(), 1);
    if (obs_inst.size() == 1) begin
      check("after ill addr", obs_addr[0], 0);
      check("after ill inst", obs_inst[0], 32'h00500113);
    end

    // Error counter saturation.
    for (int i = 0; i < 256; i++) send(3'd6, OP, 5'd0, 3'd0, 5'd0, 5'd0, 7'h0, 32'h0, "sat");
    @(negedge clk);
    check("err_cnt sat", err_cnt, 255);
    sync();
    do_clear();
    @(negedge clk);
    check("clear err_cnt", err_cnt, 0);
    sync();

    // Immediate range boundaries.
    send(3'd0, OP_IMM, 5'd1, 3'd0, 5'd2, 5'd0, 7'h0, 32'h000007FF, "I max");
    send(3'd0, OP_IMM, 5'd1, 3'd0, 5'd2, 5'd0, 7'h0, 32'h00000800, "I over");
    send(3'd0, OP_IMM, 5'd1, 3'd0, 5'd2, 5'd0, 7'h0, 32'hFFFFF800, "I min");
    send(3'd4, STORE, 5'd0, 3'd2, 5'd3, 5'd4, 7'h0, 32'hFFFFFFFF, "S -1");
    send(3'd3, BRANCH, 5'd0, 3'd1, 5'd5, 5'd6, 7'h0, 32'hFFFFF000, "B min");
    send(3'd3, BRANCH, 5'd0, 3'd1, 5'd5, 5'd6, 7'h0, 32'h00001000, "B over");
    send(3'd1, JAL, 5'd7, 3'd0, 5'd0, 5'd0, 7'h0, 32'hFFF00000, "J min");
    send(3'd1, JAL, 5'd7, 3'd0, 5'd0, 5'd0, 7'h0, 32'h00100000, "J over");
    send(3'd2, LUI, 5'd8, 3'd0, 5'd0, 5'd0, 7'h0, 32'hFFFFF000, "U top");
    send(3'd5, OP, 5'd3, 3'd0, 5'd1, 5'd2, 7'h20, 32'hDEADBEEF, "R sub");
    idle(4);
    do_clear();

    // Backpressure: two words fill the buffer, the third waits.
    bus.out_ready = 1'b0;
    obs_addr.delete(); obs_inst.delete();
    send(3'd0, OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 7'h0, 32'd1, "bp A");
    send(3'd0, OP_IMM, 5'd2, 3'd0, 5'd0, 5'd0, 7'h0, 32'd2, "bp B");
    set_req(3'd0, OP_IMM, 5'd3, 3'd0, 5'd0, 5'd0, 7'h0, 32'd3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp in_ready low", bus.in_ready, 0);
      check("bp head stable", bus.out_inst, 32'h00100093);
    end
    sync();
    bus.out_ready = 1'b1;
    wait_acc("bp C");
    idle(4);
    check("bp count", obs_inst.size(), 3);
    if (obs_inst.size() == 3) begin
      check("bp inst0", obs_inst[0], 32'h00100093);
      check("bp inst1", obs_inst[1], 32'h00200113);
      check("bp inst2", obs_inst[2], 32'h00300193);
      check("bp addr0", obs_addr[0], 0);
      check("bp addr1", obs_addr[1], 1);
      check("bp addr2", obs_addr[2], 2);
    end
    do_clear();

    // Address wrap with a 2-bit counter.
    obs_addr.delete(); obs_inst.delete();
    for (int i = 1; i <= 5; i++)
      send(3'd0, OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 7'h0, i, "wrap");
    idle(3);
    check("wrap count", obs_addr.size(), 5);
    if (obs_addr.size() == 5) begin
      check("wrap addr3", obs_addr[3], 3);
      check("wrap addr4", obs_addr[4], 0);
    end
    do_clear();

    // Clear with two words buffered and a request pending.
    bus.out_ready = 1'b0;
    send(3'd6, OP, 5'd0, 3'd0, 5'd0, 5'd0, 7'h0, 32'h0, "cl ill");
    send(3'd0, OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 7'h0, 32'd1, "cl A");
    send(3'd0, OP_IMM, 5'd2, 3'd0, 5'd0, 5'd0, 7'h0, 32'd2, "cl B");
    set_req(3'd0, OP_IMM, 5'd4, 3'd0, 5'd0, 5'd0, 7'h0, 32'd4);
    clear = 1'b1;
    @(negedge clk);
    check("clear in_ready", bus.in_ready, 0);
    sync();
    clear = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    obs_addr.delete(); obs_inst.delete();
    @(negedge clk);
    check("clear out_valid", bus.out_valid, 0);
    check("clear err_cnt", err_cnt, 0);
    check("clear sticky", err_sticky, 0);
    sync();
    send(3'd0, OP_IMM, 5'd4, 3'd0, 5'd0, 5'd0, 7'h0, 32'd4, "cl D");
    idle(2);
    check("clear next count", obs_inst.size(), 1);
    if (obs_inst.size() == 1) begin
      check("clear next addr", obs_addr[0], 0);
      check("clear next inst", obs_inst[0], 32'h00400213);
    end

    // Asynchronous reset mid-stall.
    bus.out_ready = 1'b0;
    send(3'd7, OP, 5'd0, 3'd0, 5'd0, 5'd0, 7'h0, 32'h0, "rs ill");
    send(3'd0, OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 7'h0, 32'd1, "rs A");
    send(3'd0, OP_IMM, 5'd2, 3'd0, 5'd0, 5'd0, 7'h0, 32'd2, "rs B");
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst out_valid", bus.out_valid, 0);
    check("arst out_inst", bus.out_inst, 0);
    check("arst out_addr", bus.out_addr, 0);
    check("arst in_ready", bus.in_ready, 0);
    check("arst err_cnt", err_cnt, 0);
    check("arst sticky", err_sticky, 0);
    sync();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    obs_addr.delete(); obs_inst.delete();
    send(3'd0, OP_IMM, 5'd3, 3'd0, 5'd0, 5'd0, 7'h0, 32'd3, "post rst");
    idle(2);
    check("post rst count", obs_inst.size(), 1);
    if (obs_inst.size() == 1) check("post rst addr", obs_addr[0], 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
